// File: rtl/mips_cpu_dmem_bridge.sv
// Bridges the CPU's single-cycle data port onto a wait-request memory bus, stalling the CPU via clk_enable.
// Optional statistics counters are compiled in with `define MIPS_DMEM_BRIDGE_STATS_EN.
module mips_cpu_dmem_bridge #(
   parameter int TIMEOUT = 256,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      cpu_address,
   input  logic             cpu_read,
   input  logic             cpu_write,
   input  logic [31:0]      cpu_writedata,
   output logic [31:0]      cpu_readdata,
   output logic             cpu_clk_enable,
   output logic [31:0]      avm_address,
   output logic             avm_read,
   output logic             avm_write,
   output logic [31:0]      avm_writedata,
   output logic [3:0]       avm_byteenable,
   input  logic [31:0]      avm_readdata,
   input  logic             avm_waitrequest,
   output logic             bus_error
`ifdef MIPS_DMEM_BRIDGE_STATS_EN
  ,output logic [CNT_W-1:0] stat_reads,
   output logic [CNT_W-1:0] stat_writes,
   output logic [CNT_W-1:0] stat_stalls
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   state_t            state_q;
   logic [31:0]       avm_address_q;
   logic [31:0]       avm_writedata_q;
   logic              avm_read_q;
   logic              avm_write_q;
   logic [31:0]       cpu_readdata_q;
   logic              bus_error_q;
   logic [TO_W-1:0]   to_cnt_q;
   logic [TO_W-1:0]   to_cnt_d;
   logic              to_hit;
   logic              cpu_req;

   assign cpu_req  = cpu_read | cpu_write;
   assign to_cnt_d = to_cnt_q + 1'b1;
   // Abort on the wait cycle that would bring the counter up to TIMEOUT.
   assign to_hit   = (TIMEOUT != 0) && (to_cnt_d == TO_W'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         avm_address_q   <= '0;
         avm_writedata_q <= '0;
         avm_read_q      <= 1'b0;
         avm_write_q     <= 1'b0;
         cpu_readdata_q  <= '0;
         bus_error_q     <= 1'b0;
         to_cnt_q        <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cpu_req) begin
                  avm_address_q   <= {cpu_address[31:2], 2'b00};
                  avm_writedata_q <= cpu_writedata;
                  avm_write_q     <= cpu_write;
                  avm_read_q      <= cpu_read & ~cpu_write;
                  to_cnt_q        <= '0;
                  if (cpu_read && cpu_write) bus_error_q <= 1'b1;
                  state_q         <= S_BUS;
               end
            end
            S_BUS: begin
               if (!avm_waitrequest) begin
                  avm_read_q  <= 1'b0;
                  avm_write_q <= 1'b0;
                  if (avm_read_q) cpu_readdata_q <= avm_readdata;
                  state_q     <= S_DONE;
               end else if (to_hit) begin
                  avm_read_q  <= 1'b0;
                  avm_write_q <= 1'b0;
                  to_cnt_q    <= to_cnt_d;
                  bus_error_q <= 1'b1;
                  if (avm_read_q) cpu_readdata_q <= '0;
                  state_q     <= S_DONE;
               end else begin
                  to_cnt_q <= to_cnt_d;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cpu_clk_enable = ((state_q == S_IDLE) && !cpu_req) || (state_q == S_DONE);
   assign cpu_readdata   = cpu_readdata_q;
   assign avm_address    = avm_address_q;
   assign avm_writedata  = avm_writedata_q;
   assign avm_read       = avm_read_q;
   assign avm_write      = avm_write_q;
   assign avm_byteenable = 4'hF;
   assign bus_error      = bus_error_q;

`ifdef MIPS_DMEM_BRIDGE_STATS_EN
   logic [CNT_W-1:0] stat_reads_q;
   logic [CNT_W-1:0] stat_writes_q;
   logic [CNT_W-1:0] stat_stalls_q;
   logic             bus_done;

   // Only transactions the bus acknowledged count; timeouts do not.
   assign bus_done = (state_q == S_BUS) && !avm_waitrequest;

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_reads_q  <= '0;
         stat_writes_q <= '0;
         stat_stalls_q <= '0;
      end else begin
         if (bus_done && avm_read_q && !(&stat_reads_q))
            stat_reads_q <= stat_reads_q + 1'b1;
         if (bus_done && avm_write_q && !(&stat_writes_q))
            stat_writes_q <= stat_writes_q + 1'b1;
         if (!cpu_clk_enable && !(&stat_stalls_q))
            stat_stalls_q <= stat_stalls_q + 1'b1;
      end
   end

   assign stat_reads  = stat_reads_q;
   assign stat_writes = stat_writes_q;
   assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_mips_cpu_dmem_bridge.sv
// Randomized scoreboard bench for mips_cpu_dmem_bridge: bus requests and retire responses are predicted at issue time.
module tb_mips_cpu_dmem_bridge;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_address;
   logic        cpu_read;
   logic        cpu_write;
   logic [31:0] cpu_writedata;
   logic [31:0] cpu_readdata;
   logic        cpu_clk_enable;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        bus_error;
`ifdef MIPS_DMEM_BRIDGE_STATS_EN
   logic [15:0] stat_reads;
   logic [15:0] stat_writes;
   logic [15:0] stat_stalls;
`endif

   always #5 clk = ~clk;

   mips_cpu_dmem_bridge #(.TIMEOUT(TO), .CNT_W(16)) dut (
      .clk             (clk),
      .reset           (reset),
      .cpu_address     (cpu_address),
      .cpu_read        (cpu_read),
      .cpu_write       (cpu_write),
      .cpu_writedata   (cpu_writedata),
      .cpu_readdata    (cpu_readdata),
      .cpu_clk_enable  (cpu_clk_enable),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_byteenable  (avm_byteenable),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest),
      .bus_error       (bus_error)
`ifdef MIPS_DMEM_BRIDGE_STATS_EN
     ,.stat_reads      (stat_reads),
      .stat_writes     (stat_writes),
      .stat_stalls     (stat_stalls)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rd;
      logic        wr;
      int          len;
   } bus_exp_t;

   typedef struct {
      int          stalls;
      logic [31:0] rdata;
      logic        berr;
   } done_exp_t;

   bus_exp_t  bus_q[$];
   done_exp_t done_q[$];

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state: what the CPU should observe.
   logic [31:0] m_rdata;
   logic        m_berr;
   int          m_reads, m_writes, m_stalls;

   int          wait_left = 0;
   logic [31:0] rd_val = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Memory responder: holds waitrequest for the programmed number of strobe cycles.
   always @(posedge clk) begin
      #1;
      if (avm_read || avm_write) begin
         if (wait_left > 0) begin
            avm_waitrequest = 1'b1;
            avm_readdata    = $urandom;
            wait_left--;
         end else begin
            avm_waitrequest = 1'b0;
            avm_readdata    = rd_val;
         end
      end else begin
         avm_waitrequest = 1'($urandom_range(0, 1));
         avm_readdata    = $urandom;
      end
   end

   // Monitor: checks every bus request cycle and every CPU retire against the scoreboard.
   bus_exp_t cur;
   bit       in_str = 0;
   int       str_len = 0;
   int       stall_cnt = 0;

   always @(negedge clk) begin
      if (reset) begin
         in_str    = 0;
         stall_cnt = 0;
      end else begin
         if (avm_read || avm_write) begin
            if (!in_str) begin
               if (bus_q.size() == 0) fail_now("unexpected bus request");
               else cur = bus_q.pop_front();
               in_str  = 1;
               str_len = 0;
            end
            str_len++;
            chk("avm_address", avm_address, cur.addr);
            chk("avm_writedata", avm_writedata, cur.wdata);
            chk("avm_read", 32'(avm_read), 32'(cur.rd));
            chk("avm_write", 32'(avm_write), 32'(cur.wr));
            chk("avm_byteenable", 32'(avm_byteenable), 32'hF);
         end else if (in_str) begin
            chk("strobe_len", str_len, cur.len);
            in_str = 0;
         end
         if (!cpu_clk_enable) begin
            stall_cnt++;
         end else if (stall_cnt > 0) begin
            if (done_q.size() == 0) begin
               fail_now("unexpected retire");
            end else begin
               done_exp_t d;
               d = done_q.pop_front();
               chk("stall_cycles", stall_cnt, d.stalls);
               chk("cpu_readdata", cpu_readdata, d.rdata);
               chk("bus_error", 32'(bus_error), 32'(d.berr));
            end
            stall_cnt = 0;
         end
      end
   end

   task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input int waits, input logic [31:0] rv);
      bus_exp_t  be;
      done_exp_t de;
      bit        tout, is_rd, retired;
      @(posedge clk); #1;
      tout     = (waits >= TO);
      is_rd    = rd && !wr;
      be.addr  = a - (a % 4);
      be.wdata = wd;
      be.rd    = is_rd;
      be.wr    = wr;
      be.len   = tout ? TO : waits + 1;
      bus_q.push_back(be);
      if (is_rd) m_rdata = tout ? 32'h0 : rv;
      if (tout || (rd && wr)) m_berr = 1'b1;
      if (!tout) begin
         if (is_rd) m_reads++;
         else m_writes++;
      end
      m_stalls += 1 + be.len;
      de.stalls = 1 + be.len;
      de.rdata  = m_rdata;
      de.berr   = m_berr;
      done_q.push_back(de);
      wait_left     = waits;
      rd_val        = rv;
      cpu_read      = rd;
      cpu_write     = wr;
      cpu_address   = a;
      cpu_writedata = wd;
      retired = 0;
      for (int c = 0; c < 64 && !retired; c++) begin
         @(negedge clk);
         if (cpu_clk_enable) retired = 1;
      end
      if (!retired) fail_now("retire timeout");
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   task automatic chk_stats();
`ifdef MIPS_DMEM_BRIDGE_STATS_EN
      chk("stat_reads", 32'(stat_reads), 32'(m_reads));
      chk("stat_writes", 32'(stat_writes), 32'(m_writes));
      chk("stat_stalls", 32'(stat_stalls), 32'(m_stalls));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
      cpu_address = '0; cpu_writedata = '0;
      m_rdata = '0; m_berr = 1'b0; m_reads = 0; m_writes = 0; m_stalls = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst avm_read", 32'(avm_read), 0);
      chk("rst avm_write", 32'(avm_write), 0);
      chk("rst avm_address", avm_address, 0);
      chk("rst avm_writedata", avm_writedata, 0);
      chk("rst cpu_readdata", cpu_readdata, 0);
      chk("rst bus_error", 32'(bus_error), 0);
      chk("rst cpu_clk_enable", 32'(cpu_clk_enable), 1);
      chk_stats();

      // Zero-wait misaligned read, then write with three wait cycles.
      do_txn(1, 0, 32'h1003, 32'h0, 0, 32'hCAFEF00D);
      do_txn(0, 1, 32'h2000, 32'h12345678, 3, 32'h0);
      idle(2);
      // Back-to-back reads.
      do_txn(1, 0, 32'h10, 32'h0, 0, 32'h1111AAAA);
      do_txn(1, 0, 32'h14, 32'h0, 0, 32'h2222BBBB);

      for (int i = 0; i < 40; i++) begin
         bit w;
         w = 1'($urandom_range(0, 1));
         do_txn(!w, w, $urandom, $urandom, $urandom_range(0, TO - 1), $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
      end
      idle(1);
      chk("bus_error before timeout", 32'(bus_error), 0);
      chk_stats();

      // Stuck bus: timeout, then a normal read sees bus_error still set.
      do_txn(1, 0, 32'h3000, 32'h0, 1000, 32'hDEADBEEF);
      do_txn(1, 0, 32'h3004, 32'h0, 1, 32'h55AA55AA);
      idle(1);
      chk_stats();

      // Reset while BUS is waiting.
      @(posedge clk); #1;
      begin
         bus_exp_t be;
         be.addr = 32'h40; be.wdata = 32'h0; be.rd = 1'b1; be.wr = 1'b0; be.len = 0;
         bus_q.push_back(be);
      end
      wait_left = 1000; cpu_read = 1'b1; cpu_address = 32'h40; cpu_writedata = 32'h0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midbus rst avm_read", 32'(avm_read), 0);
      chk("midbus rst avm_address", avm_address, 0);
      chk("midbus rst cpu_readdata", cpu_readdata, 0);
      chk("midbus rst bus_error", 32'(bus_error), 0);
      wait_left = 0; cpu_read = 1'b0; reset = 1'b0;
      m_rdata = '0; m_berr = 1'b0; m_reads = 0; m_writes = 0; m_stalls = 0;
      @(negedge clk);
      chk("post rst cpu_clk_enable", 32'(cpu_clk_enable), 1);
      chk("post rst avm_read", 32'(avm_read), 0);
      chk_stats();

      // Read and write together: write wins and flags bus_error.
      do_txn(1, 1, 32'h81, 32'hA5A5A5A5, 0, 32'h77777777);
      chk_stats();
      idle(5);
      @(negedge clk);
      chk("bus_q drained", bus_q.size(), 0);
      chk("done_q drained", done_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
